mem_bus_master: RTL
===================

# mem_bus_master

CPU-side initiator for the single-port data memory on the shared 8-bit bidirectional data bus. Accepts one read or write request at a time from the core over a valid/ready handshake and sequences `address`, `read_en`, `write_en` and the data bus to the memory's posedge-sampled protocol. It is the only other driver on the memory data bus. Read data returns to the core as a one-cycle response pulse.

## Interface
- `ADDR_W`, default 5: memory address width (32 locations).
- `DATA_W`, default 8: data bus width.

- `clk`  in  1  system clock, posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read; sampled on accept.
- `req_addr`  in  ADDR_W  request address; sampled on accept.
- `req_wdata`  in  DATA_W  write data; sampled on accept.
- `rsp_valid`  out  1  one-cycle pulse: `rsp_rdata` holds read result.
- `rsp_rdata`  out  DATA_W  last read data; held until next read completes.
- `mem_address`  out  ADDR_W  to memory `address`.
- `mem_read_en`  out  1  to memory `read_en`.
- `mem_write_en`  out  1  to memory `write_en`.
- `mem_data_bus`  inout  DATA_W  shared memory data bus.

## Operation
- States: IDLE, RD_REQ, RD_CAP, WR, TURN (TURN only with macro).
- Accept = `req_valid && req_ready` at a posedge; address/data/type registered; block ignores inputs until back in IDLE. Requester holds `req_valid` and payload until accepted.
- IDLE -> RD_REQ (read) or WR (write) on accept; otherwise stay.
- RD_REQ: `mem_read_en`=1; memory latches its buffer at end of cycle. -> RD_CAP.
- RD_CAP: `mem_read_en`=1; memory drives bus; block samples `mem_data_bus` into `rsp_rdata` at end of cycle, sets `rsp_valid` for next cycle. -> IDLE.
- WR: `mem_write_en`=1, `mem_data_bus` driven with registered write data; memory writes at end of cycle. -> IDLE (or TURN).
- `mem_data_bus` driven only in WR; high-Z in every other state and during reset. `mem_read_en` and `mem_write_en` never both high.
- All `mem_*` outputs and `rsp_*` registered. `mem_address` updates on accept, held through the operation, retains last value in IDLE.
- Writes are posted: no response pulse.
- Reset (async, any state): state IDLE, `mem_read_en`=0, `mem_write_en`=0, bus released, `mem_address`=0, `rsp_valid`=0, `rsp_rdata`=0. In-flight read is dropped with no response; in-flight write may or may not land in memory. `req_ready` reads 1 while `rst_n` is low but no accept occurs until after release.

## Timing
- Read: accept at edge E0; RD_REQ cycle E0–E1; RD_CAP cycle E1–E2; `rsp_valid`=1 in cycle E2–E3 with data. Latency accept-to-response 3 cycles; `req_ready` low 2 cycles.
- Write: accept at E0; WR cycle E0–E1; memory updated at E1; `req_ready` high again from E1 (E2 with macro).
- Back-to-back: next accept possible at the edge that enters IDLE + 1, i.e. a new request is accepted in the first IDLE cycle; `rsp_valid` of a read overlaps that IDLE cycle.
- Address wrap: no arithmetic; any ADDR_W value, 31 valid.

## Configuration
- `MEM_BUS_TURNAROUND_EN` defined: after WR the FSM spends one TURN cycle (both enables 0, bus high-Z, `req_ready` 0) before IDLE; write occupies 2 cycles.
- Undefined: TURN state absent; WR -> IDLE directly; write occupies 1 cycle.

## Test plan
- Reset mid-read: assert `rst_n`=0 during RD_CAP -> `mem_read_en`=0 and bus high-Z immediately, no `rsp_valid`, `rsp_rdata`=8'h00, `req_ready`=1 after release.
- Write 8'hA5 to 5'h03, then read 5'h03 -> `rsp_valid` exactly 3 cycles after read accept, `rsp_rdata`=8'hA5.
- Write all 32 addresses with data = addr ^ 8'h5A, read back 0..31 -> every response matches, address 31 correct, no wrap errors.
- Hold `req_valid` with changing payload during busy cycles -> only value present at accept edge appears on `mem_address`/bus; no second accept until IDLE.
- Bus monitor over whole run -> block drives `mem_data_bus` only while `mem_write_en`=1, enables never both high, no X on bus in read sample cycle.
- With `MEM_BUS_TURNAROUND_EN`: write then read -> `req_ready` low 2 cycles after write accept, one idle bus cycle between `mem_write_en` fall and `mem_read_en` rise; without macro, low 1 cycle.

Source files
------------

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_master
// Purpose  : Core-side initiator sequencing single reads/writes onto the
//            shared single-port data memory and its bidirectional data bus.
// Options  : MEM_BUS_TURNAROUND_EN - adds one idle TURN cycle after each write.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_en,
    output logic              mem_write_en,
    inout  wire  [DATA_W-1:0] mem_data_bus
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_RD_REQ = 3'd1;
    localparam logic [2:0] c_RD_CAP = 3'd2;
    localparam logic [2:0] c_WR     = 3'd3;
`ifdef MEM_BUS_TURNAROUND_EN
    localparam logic [2:0] c_TURN   = 3'd4;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              w_accept;
    logic              w_read_en_nxt;
    logic              w_write_en_nxt;
    logic              w_rsp_valid_nxt;
    logic              r_read_en;
    logic              r_write_en;
    logic              r_rsp_valid;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    assign req_ready = (r_state == c_IDLE);
    assign w_accept  = req_valid && req_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_state_nxt = req_write ? c_WR : c_RD_REQ;
            c_RD_REQ: w_state_nxt = c_RD_CAP;
            c_RD_CAP: w_state_nxt = c_IDLE;
`ifdef MEM_BUS_TURNAROUND_EN
            c_WR:     w_state_nxt = c_TURN;
            c_TURN:   w_state_nxt = c_IDLE;
`else
            c_WR:     w_state_nxt = c_IDLE;
`endif
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the enables are registered
    // yet still line up with the state they belong to.
    always_comb begin
        w_read_en_nxt   = (w_state_nxt == c_RD_REQ) || (w_state_nxt == c_RD_CAP);
        w_write_en_nxt  = (w_state_nxt == c_WR);
        w_rsp_valid_nxt = (r_state == c_RD_CAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_en   <= 1'b0;
            r_write_en  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_address   <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            r_read_en   <= w_read_en_nxt;
            r_write_en  <= w_write_en_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            if (w_accept) begin
                r_address <= req_addr;
                r_wdata   <= req_wdata;
            end
            // Memory drives the bus throughout RD_CAP; capture at its end.
            if (r_state == c_RD_CAP) begin
                r_rdata <= mem_data_bus;
            end
        end
    end

    assign mem_read_en  = r_read_en;
    assign mem_write_en = r_write_en;
    assign mem_address  = r_address;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rdata;

    // The write enable doubles as the bus drive enable, so the bus is only
    // ever driven while a write is being presented.
    assign mem_data_bus = r_write_en ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire
